// File: rtl/mux_key_with_default.sv
// mux_key_with_default: looks up a key in a packed table of (key, data)
// pairs and drives the data of the lowest-index matching entry, or
// default_out when no entry matches. hit flags that some entry matched.
//
// Entry i sits at lut[i*PAIR_LEN +: PAIR_LEN].
// Within each entry, the key is in the upper KEY_LEN bits and the data is
// in the lower DATA_LEN bits.
//
// Optional macro MUX_KEY_OUT_REG_EN:
// - Defined: out and hit are registered. This adds one cycle of latency
//   and an asynchronous active-low clear.
// - Undefined (default): the lookup is purely combinational, and clk and
//   rst_n have no effect.
// There is no handshake. The inputs are expected to be stable around the
// sampling edge.
module mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [DATA_LEN-1:0] sel_data;
  logic                sel_hit;

  // Priority lookup: the scan runs from the top entry down, so entry 0
  // has the last word and duplicate keys resolve to the lowest index.
  // Data is only read from an entry whose key compared equal, so junk in
  // unmatched entries never reaches the output.
  always_comb begin
    sel_data = default_out;
    sel_hit  = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (lut[i*PAIR_LEN + DATA_LEN +: KEY_LEN] == key) begin
        sel_data = lut[i*PAIR_LEN +: DATA_LEN];
        sel_hit  = 1'b1;
      end
    end
  end

`ifdef MUX_KEY_OUT_REG_EN
  logic [DATA_LEN-1:0] out_d, out_q;
  logic                hit_d, hit_q;

  // Next-state of the output registers: the lookup result every cycle.
  always_comb begin
    out_d = sel_data;
    hit_d = sel_hit;
  end

  // Output registers: captured on every edge, cleared at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out_d;
      hit_q <= hit_d;
    end
  end

  assign out = out_q;
  assign hit = hit_q;
`else
  // Same-cycle path: clk and rst_n are kept only for port compatibility.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign out = sel_data;
  assign hit = sel_hit;
`endif

endmodule

// File: tb/tb_mux_key_with_default.sv
// Self-checking bench for mux_key_with_default.
// It exercises three instances of the design:
// - dut_a: the operand-select table with three entries.
// - dut_b: a four-entry table that contains a duplicate key.
// - dut_c: an 8-entry, 3-bit-key table with a randomized permutation of keys.
// The bench follows whichever build is compiled, with or without
// MUX_KEY_OUT_REG_EN.
module tb_mux_key_with_default;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // ---------------- instance A / B: 7-bit key, 32-bit data ----------------
  logic [6:0]      key_ab;
  logic [W-1:0]    dflt_ab;
  logic [3*39-1:0] lut_a;
  logic [4*39-1:0] lut_b;
  logic [W-1:0]    out_a, out_b;
  logic            hit_a, hit_b;

  localparam logic [W-1:0] PC = 32'h8000_0010;

  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .key(key_ab), .default_out(dflt_ab),
    .lut(lut_a), .out(out_a), .hit(hit_a)
  );

  mux_key_with_default #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .key(key_ab), .default_out(dflt_ab),
    .lut(lut_b), .out(out_b), .hit(hit_b)
  );

  // ---------------- instance C: random sweep ----------------
  logic [2:0]     key_c;
  logic [15:0]    dflt_c;
  logic [8*19-1:0] lut_c;
  logic [15:0]    out_c;
  logic           hit_c;

  mux_key_with_default #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .key(key_c), .default_out(dflt_c),
    .lut(lut_c), .out(out_c), .hit(hit_c)
  );

  // ---------------- scoreboard ----------------
  logic [W:0]  exp_q[$];    // {hit, out} for dut_a then dut_b
  logic [16:0] exp_c_q[$];  // {hit, out} for dut_c

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hit=%b out=%h, expected hit=%b out=%h",
               name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  // Wait until the DUT has produced the result for the inputs just driven.
  task automatic settle();
`ifdef MUX_KEY_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic drive_ab(input logic [6:0] k, input logic [W-1:0] d,
                          input logic [W:0] ea, input logic [W:0] eb);
    key_ab  = k;
    dflt_ab = d;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
  endtask

  task automatic compare_ab(input string name);
    logic [W:0] e;
    if (exp_q.size() < 2) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard underflow", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_a"}, {hit_a, out_a}, e);
      e = exp_q.pop_front();
      check({name, "_b"}, {hit_b, out_b}, e);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]   key;
    logic [W-1:0] dflt;
    logic [W:0]   exp_a;
    logic [W:0]   exp_b;
  } vec_t;

  localparam logic [W-1:0] DF = 32'h1234_5678;

  vec_t vecs[9];

  int perm[8];
  logic [15:0] pdata[8];

  initial begin
    vecs[0] = '{7'b0010111, DF, {1'b1, PC},           {1'b0, DF}};
    vecs[1] = '{7'b0110111, DF, {1'b1, 32'h0},        {1'b0, DF}};
    vecs[2] = '{7'b0110011, DF, {1'b0, DF},           {1'b0, DF}};
    vecs[3] = '{7'b1101111, DF, {1'b1, PC},           {1'b0, DF}};
    vecs[4] = '{7'b0000011, DF, {1'b0, DF},           {1'b1, 32'hAAAA_AAAA}};
    vecs[5] = '{7'b0100011, DF, {1'b0, DF},           {1'b1, 32'hCCCC_CCCC}};
    vecs[6] = '{7'b0010011, DF, {1'b0, DF},           {1'b1, 32'hDDDD_DDDD}};
    vecs[7] = '{7'b1111111, 32'hFFFF_0000, {1'b0, 32'hFFFF_0000}, {1'b0, 32'hFFFF_0000}};
    vecs[8] = '{7'b0110111, 32'h0F0F_A5A5, {1'b1, 32'h0}, {1'b0, 32'h0F0F_A5A5}};

    lut_a  = {7'b0010111, PC, 7'b0110111, 32'h0, 7'b1101111, PC};
    lut_b  = {7'b0000011, 32'hBBBB_BBBB, 7'b0100011, 32'hCCCC_CCCC,
              7'b0000011, 32'hAAAA_AAAA, 7'b0010011, 32'hDDDD_DDDD};
    key_ab  = 7'b0010111;
    dflt_ab = DF;
    key_c   = '0;
    dflt_c  = '0;
    lut_c   = '0;
    rst_n   = 1'b0;

    // ---------------- reset behaviour ----------------
`ifdef MUX_KEY_OUT_REG_EN
    // Reset held across an edge with a matching key: outputs stay cleared.
    @(posedge clk);
    #1;
    check("rst_hold", {hit_a, out_a}, '0);
    // Release with a non-matching key; first edge captures the default.
    @(negedge clk);
    rst_n  = 1'b1;
    key_ab = 7'b0110011;
    @(posedge clk);
    #1;
    check("first_capture", {hit_a, out_a}, {1'b0, DF});
    // New key is not visible until the next rising edge.
    @(negedge clk);
    key_ab = 7'b0010111;
    #1;
    check("before_edge", {hit_a, out_a}, {1'b0, DF});
    @(posedge clk);
    #1;
    check("one_edge_later", {hit_a, out_a}, {1'b1, PC});
    // Asynchronous assertion between edges clears at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {hit_a, out_a}, '0);
    #1;
    rst_n = 1'b1;
`else
    // Reset has no effect on the combinational path.
    #1;
    check("rst_low_match", {hit_a, out_a}, {1'b1, PC});
    rst_n = 1'b1;
    #1;
    check("rst_high_match", {hit_a, out_a}, {1'b1, PC});
    rst_n = 1'b0;
    #1;
    check("rst_low_again", {hit_a, out_a}, {1'b1, PC});
    rst_n = 1'b1;
    #1;
`endif

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_ab(vecs[i].key, vecs[i].dflt, vecs[i].exp_a, vecs[i].exp_b);
      settle();
      compare_ab($sformatf("vec%0d", i));
    end

    // ---------------- random sweep: distinct keys, always hit ----------------
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(i, 0);
        t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
        pdata[i] = 16'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        lut_c[i*19 +: 19] = {3'(perm[i]), pdata[i]};
      end
      dflt_c = 16'($urandom);
      for (int c = 0; c < 100; c++) begin
        logic [16:0] e;
        logic [16:0] got;
        if (c != 0) @(negedge clk);
        key_c = 3'($urandom_range(7, 0));
        e = {1'b0, dflt_c};
        for (int j = 0; j < 8; j++) begin
          if (perm[j] == int'(key_c)) e = {1'b1, pdata[j]};
        end
        exp_c_q.push_back(e);
        settle();
        got = exp_c_q.pop_front();
        check($sformatf("sweep_p%0d_c%0d", p, c), {16'h0, hit_c, out_c}, {16'h0, got});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
